// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and glyph table for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    // Segment order is {A,B,C,D,E,F,G}, bit 6 = A.
    localparam logic [6:0] GLYPH_0   = 7'h7E;
    localparam logic [6:0] GLYPH_1   = 7'h30;
    localparam logic [6:0] GLYPH_2   = 7'h6D;
    localparam logic [6:0] GLYPH_3   = 7'h79;
    localparam logic [6:0] GLYPH_4   = 7'h33;
    localparam logic [6:0] GLYPH_5   = 7'h5B;
    localparam logic [6:0] GLYPH_6   = 7'h5F;
    localparam logic [6:0] GLYPH_7   = 7'h70;
    localparam logic [6:0] GLYPH_8   = 7'h7F;
    localparam logic [6:0] GLYPH_9   = 7'h7B;
    localparam logic [6:0] GLYPH_A   = 7'h77;
    localparam logic [6:0] GLYPH_B   = 7'h1F;
    localparam logic [6:0] GLYPH_C   = 7'h4E;
    localparam logic [6:0] GLYPH_D   = 7'h3D;
    localparam logic [6:0] GLYPH_E   = 7'h4F;
    localparam logic [6:0] GLYPH_F   = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value-side controls and display-side pins of the scan controller.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  lzs;
    logic [DIGITS-1:0]     dig_sel;
    logic                  a;
    logic                  b;
    logic                  c;
    logic                  d;
    logic                  e;
    logic                  f;
    logic                  g;
    logic                  frame_done;

    modport master (
        output enable, load, value, lzs,
        input  dig_sel, a, b, c, d, e, f, g, frame_done
    );

    modport slave (
        input  enable, load, value, lzs,
        output dig_sel, a, b, c, d, e, f, g, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// Hex nibble to 7-segment glyph lookup, purely combinational.
module hex_seg_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Table lookup; bit 3 of the nibble is the MSB.
    always_comb begin
        seg_o = SEG_BLANK;
        case (nib_i)
            4'h0:    seg_o = GLYPH_0;
            4'h1:    seg_o = GLYPH_1;
            4'h2:    seg_o = GLYPH_2;
            4'h3:    seg_o = GLYPH_3;
            4'h4:    seg_o = GLYPH_4;
            4'h5:    seg_o = GLYPH_5;
            4'h6:    seg_o = GLYPH_6;
            4'h7:    seg_o = GLYPH_7;
            4'h8:    seg_o = GLYPH_8;
            4'h9:    seg_o = GLYPH_9;
            4'hA:    seg_o = GLYPH_A;
            4'hB:    seg_o = GLYPH_B;
            4'hC:    seg_o = GLYPH_C;
            4'hD:    seg_o = GLYPH_D;
            4'hE:    seg_o = GLYPH_E;
            4'hF:    seg_o = GLYPH_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with dead-time blanking.
//
//  state  | meaning
//  -------+---------------------------------------------------------
//  OFF    | scanning stopped, selects and segments dark
//  BLANK  | dead time between digits, everything dark for DEAD cycles
//  SHOW   | digit `index` lit with its glyph for DWELL cycles
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 50000,
    parameter int DEAD   = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    seg_scan_ctrl_if.slave  bus
);

    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CMAX = (DWELL > DEAD) ? DWELL : DEAD;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [CW-1:0] DWELL_TC = CW'(DWELL - 1);
    localparam logic [CW-1:0] DEAD_TC  = CW'(DEAD - 1);

    scan_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         index_q, index_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [4*DIGITS-1:0]   display_q, display_d;
    logic                  pending_q, pending_d;
    logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;
    logic [6:0]            seg_q, seg_d;
    logic                  frame_done_q, frame_done_d;

    logic                  wrap;
    logic                  start;
    logic [3:0]            nib_sel;
    logic                  sup;
    logic [6:0]            dec_seg;

    hex_seg_decode u_dec (
        .nib_i (nib_sel),
        .seg_o (dec_seg)
    );

    // FSM state, phase counter and digit index registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            index_q <= index_d;
        end
    end

    // Next-state: dead time, dwell, digit advance and frame wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        index_d = index_q;
        wrap    = 1'b0;
        start   = 1'b0;
        if (!bus.enable) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            index_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    index_d = '0;
                    start   = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == DEAD_TC) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_TC) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (index_q == LAST_IDX) begin
                            index_d = '0;
                            wrap    = 1'b1;
                        end else begin
                            index_d = index_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    index_d = '0;
                end
            endcase
        end
    end

    // Pick the current digit's nibble and decide leading-zero suppression.
    always_comb begin
        nib_sel = 4'h0;
        sup     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (index_q == IW'(i)) begin
                nib_sel = display_q[4*i +: 4];
                sup     = (i != 0) && ((display_q >> (4*i)) == '0);
            end
        end
    end

    // Outputs computed from the next state so selects and segments switch together.
    always_comb begin
        dig_sel_d    = '0;
        seg_d        = SEG_BLANK;
        frame_done_d = wrap;
        if (state_d == ST_SHOW) begin
            dig_sel_d = DIGITS'(1) << index_q;
            seg_d     = (bus.lzs && sup) ? SEG_BLANK : dec_seg;
        end
    end

    // Registered display pins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dig_sel_q    <= '0;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            dig_sel_q    <= dig_sel_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Shadow capture on Load; display only refreshes at frame boundaries or scan start.
    always_comb begin
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        if ((wrap || start) && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            shadow_d  = bus.value;
            pending_d = 1'b1;
        end
    end

    // Value storage registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q  <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
        end
    end

    assign bus.dig_sel    = dig_sel_q;
    assign bus.a          = seg_q[6];
    assign bus.b          = seg_q[5];
    assign bus.c          = seg_q[4];
    assign bus.d          = seg_q[3];
    assign bus.e          = seg_q[2];
    assign bus.f          = seg_q[1];
    assign bus.g          = seg_q[0];
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a digit scoreboard.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DWELL  = 4;
    localparam int DEAD   = 2;

    localparam logic [6:0] G_0 = 7'h7E;
    localparam logic [6:0] G_1 = 7'h30;
    localparam logic [6:0] G_2 = 7'h6D;
    localparam logic [6:0] G_3 = 7'h79;
    localparam logic [6:0] G_4 = 7'h33;
    localparam logic [6:0] G_5 = 7'h5B;
    localparam logic [6:0] G_6 = 7'h5F;
    localparam logic [6:0] G_7 = 7'h70;
    localparam logic [6:0] G_8 = 7'h7F;
    localparam logic [6:0] G_9 = 7'h7B;
    localparam logic [6:0] G_A = 7'h77;
    localparam logic [6:0] G_B = 7'h1F;
    localparam logic [6:0] G_C = 7'h4E;
    localparam logic [6:0] G_F = 7'h47;
    localparam logic [6:0] OFF = 7'h00;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .DEAD(DEAD)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [6:0] seg_obs;
    assign seg_obs = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};

    int   n_vec = 0;
    int   n_err = 0;
    bit   timing_chk = 1'b0;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] sel, input logic [6:0] seg);
        exp_t e;
        e.sel = sel;
        e.seg = seg;
        sb_q.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        push(4'b0001, s0);
        push(4'b0010, s1);
        push(4'b0100, s2);
        push(4'b1000, s3);
    endtask

    task automatic wait_fd(input int max_cyc, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (bus.frame_done !== 1'b1 && n < max_cyc);
        check("frame_done_seen", 32'(bus.frame_done), 32'd1);
    endtask

    // Monitor: score each digit as it lights, and check dwell / dead-time lengths.
    logic [3:0] prev_sel = 4'b0;
    int         lit_n = 0;
    int         blk_n = 0;
    bit         lit_v = 1'b0;
    bit         blk_v = 1'b0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst) begin
            lit_v = 1'b0;
            blk_v = 1'b0;
        end else begin
            if (bus.dig_sel != 4'b0 && prev_sel == 4'b0) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_digit", 32'(bus.dig_sel), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_digsel", 32'(bus.dig_sel), 32'(mon_e.sel));
                    check("sb_segs", 32'(seg_obs), 32'(mon_e.seg));
                end
            end
            if (!timing_chk) begin
                lit_v = 1'b0;
                blk_v = 1'b0;
            end else if (bus.dig_sel != 4'b0) begin
                if (prev_sel == 4'b0) begin
                    if (blk_v) check("blank_len", 32'(blk_n), 32'(DEAD));
                    blk_v = 1'b0;
                    lit_v = 1'b1;
                    lit_n = 1;
                end else begin
                    lit_n++;
                end
            end else begin
                if (prev_sel != 4'b0) begin
                    if (lit_v) check("dwell_len", 32'(lit_n), 32'(DWELL));
                    lit_v = 1'b0;
                    blk_v = 1'b1;
                    blk_n = 1;
                end else begin
                    blk_n++;
                end
            end
        end
        prev_sel = bus.dig_sel;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        bus.value  = '0;
        bus.lzs    = 1'b0;
        rst        = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_digsel", 32'(bus.dig_sel), 32'd0);
        check("rst_segs", 32'(seg_obs), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;

        // Load 0x1208 while off, then start scanning
        bus.load  = 1'b1;
        bus.value = 16'h1208;
        tick(1);
        bus.load = 1'b0;
        tick(2);
        check("off_no_scan", 32'(bus.dig_sel), 32'd0);
        push_frame(G_8, G_0, G_2, G_1);
        timing_chk = 1'b1;
        bus.enable = 1'b1;
        wait_fd(40, n);
        check("first_frame_len", 32'(n), 32'(1 + 4*(DEAD+DWELL)));
        tick(1);
        check("frame_done_one_cycle", 32'(bus.frame_done), 32'd0);
        push_frame(G_8, G_0, G_2, G_1);

        // Load 0xFFFF while digit 1 is lit: current frame keeps 0x1208
        tick(7);
        check("digit1_lit", 32'(bus.dig_sel), 32'b0010);
        bus.load  = 1'b1;
        bus.value = 16'hFFFF;
        tick(1);
        bus.load = 1'b0;
        push_frame(G_F, G_F, G_F, G_F);
        wait_fd(40, n);
        wait_fd(40, n);
        check("frame_period", 32'(n), 32'(4*(DEAD+DWELL)));

        // Leading-zero suppression
        bus.lzs   = 1'b1;
        bus.load  = 1'b1;
        bus.value = 16'h0007;
        tick(1);
        bus.load = 1'b0;
        push_frame(G_F, G_F, G_F, G_F);
        push_frame(G_7, OFF, OFF, OFF);
        wait_fd(40, n);
        bus.load  = 1'b1;
        bus.value = 16'h0000;
        tick(1);
        bus.load = 1'b0;
        push(4'b0001, G_0);
        push(4'b0010, OFF);
        push(4'b0100, OFF);
        wait_fd(40, n);

        // Drop enable during digit 2, then re-enable
        tick(14);
        check("digit2_lit", 32'(bus.dig_sel), 32'b0100);
        check("digit2_suppressed", 32'(seg_obs), 32'd0);
        timing_chk = 1'b0;
        bus.enable = 1'b0;
        tick(1);
        check("disable_digsel", 32'(bus.dig_sel), 32'd0);
        check("disable_segs", 32'(seg_obs), 32'd0);
        tick(3);
        check("off_stays_dark", 32'(bus.dig_sel), 32'd0);
        bus.lzs = 1'b0;
        push_frame(G_0, G_0, G_0, G_0);
        bus.enable = 1'b1;
        tick(1);
        check("reen_blank1", 32'(bus.dig_sel), 32'd0);
        tick(1);
        check("reen_blank2", 32'(bus.dig_sel), 32'd0);
        tick(1);
        check("reen_digit0", 32'(bus.dig_sel), 32'b0001);
        timing_chk = 1'b1;
        wait_fd(40, n);

        // Load on the exact frame-wrap edge with an older load pending
        bus.load  = 1'b1;
        bus.value = 16'h3456;
        tick(1);
        bus.load = 1'b0;
        push_frame(G_0, G_0, G_0, G_0);
        tick(22);
        bus.load  = 1'b1;
        bus.value = 16'h9ABC;
        tick(1);
        bus.load = 1'b0;
        check("load_on_wrap_edge", 32'(bus.frame_done), 32'd1);
        push_frame(G_6, G_5, G_4, G_3);
        push_frame(G_C, G_B, G_A, G_9);
        wait_fd(40, n);
        check("wrap_period_a", 32'(n), 32'(4*(DEAD+DWELL)));
        wait_fd(40, n);
        check("wrap_period_b", 32'(n), 32'(4*(DEAD+DWELL)));

        // Asynchronous reset while a digit is lit
        push(4'b0001, G_C);
        tick(3);
        check("pre_reset_lit", 32'(bus.dig_sel), 32'b0001);
        timing_chk = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_digsel", 32'(bus.dig_sel), 32'd0);
        check("async_rst_segs", 32'(seg_obs), 32'd0);
        check("async_rst_frame_done", 32'(bus.frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(4'b0001, G_0);
        tick(1);
        check("post_rst_blank1", 32'(bus.dig_sel), 32'd0);
        tick(1);
        check("post_rst_blank2", 32'(bus.dig_sel), 32'd0);
        tick(1);
        check("post_rst_digit0", 32'(bus.dig_sel), 32'b0001);
        check("post_rst_segs", 32'(seg_obs), 32'(G_0));
        bus.enable = 1'b0;
        tick(2);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
